// File: rtl/u_d_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package u_d_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Midscale value 2**(width-1), used as the default preset.
  function automatic longint unsigned midscale(input int unsigned width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/u_d_decim_ctrl.sv
// Decimation control: counts enabled steps and snapshots the post-step count.
module u_d_decim_ctrl #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      DECIM   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clr,
  input  logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] snap,
  output logic             snap_vld
);

  localparam int unsigned   DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);

  logic [DW-1:0] dcnt;

  // Decimation counter, snapshot register and one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      snap     <= RST_VAL;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      if (clr) begin
        dcnt <= '0;
      end else if (step) begin
        if (dcnt == DLAST) begin
          dcnt     <= '0;
          snap     <= q_next;
          snap_vld <= 1'b1;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/u_d_counter_param.sv
// Parametrised up/down feedback counter with wrap/saturate, sticky boundary
// flags and a decimated snapshot output.
module u_d_counter_param
  import u_d_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(midscale(WIDTH)),
  parameter int unsigned      SAT_EN  = MODE_WRAP,
  parameter int unsigned      DECIM   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             u_d,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic [WIDTH-1:0] snap,
  output logic             snap_vld
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;
  localparam bit               SAT   = (SAT_EN == MODE_SAT);

  logic [WIDTH-1:0] q_step_c;
  logic             ovf_evt_c;
  logic             unf_evt_c;
  logic             step_c;

  // A step only happens when enabled and not pre-empted by clr/load.
  assign step_c = en & ~clr & ~load;

  assign at_max = (q == Q_MAX);
  assign at_min = (q == '0);

  // Candidate post-step value and boundary events for the current direction.
  always_comb begin
    q_step_c  = q;
    ovf_evt_c = 1'b0;
    unf_evt_c = 1'b0;
    if (u_d) begin
      if (q == Q_MAX) begin
        ovf_evt_c = 1'b1;
        q_step_c  = SAT ? Q_MAX : '0;
      end else begin
        q_step_c = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        unf_evt_c = 1'b1;
        q_step_c  = SAT ? '0 : Q_MAX;
      end else begin
        q_step_c = q - WIDTH'(1);
      end
    end
  end

  // Count register: clr > load > step > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_step_c;
    end
  end

  // Sticky flags; a coincident boundary event beats sticky_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (step_c & ovf_evt_c) | (ovf & ~sticky_clr);
      unf <= (step_c & unf_evt_c) | (unf & ~sticky_clr);
    end
  end

  u_d_decim_ctrl #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL),
    .DECIM   (DECIM)
  ) u_decim (
    .clk      (clk),
    .rst      (rst),
    .step     (step_c),
    .clr      (clr),
    .q_next   (q_step_c),
    .snap     (snap),
    .snap_vld (snap_vld)
  );

endmodule

// File: tb/tb_u_d_counter_param.sv
// Scoreboard bench: three counter configurations share one random/directed
// stimulus stream and are checked against a plain-arithmetic reference model.
module tb_u_d_counter_param;

  localparam int unsigned WID  [3] = '{16, 16, 4};
  localparam int unsigned SATP [3] = '{0, 1, 0};
  localparam int unsigned DECP [3] = '{4, 8, 1};
  localparam int unsigned RV   [3] = '{32'h8000, 32'h8000, 32'h8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, u_d = 1'b0, clr = 1'b0, load = 1'b0, sticky_clr = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] q_a, q_b, snap_a, snap_b;
  logic [3:0]  q_c, snap_c;
  logic [2:0]  damax, damin, dovf, dunf, dvld;
  logic [2:0][15:0] dq, dsnap;

  assign dq    = {{12'd0, q_c}, q_b, q_a};
  assign dsnap = {{12'd0, snap_c}, snap_b, snap_a};

  u_d_counter_param #(.WIDTH(16), .SAT_EN(0), .DECIM(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .clr(clr), .load(load),
    .load_val(load_val), .sticky_clr(sticky_clr), .q(q_a), .at_max(damax[0]),
    .at_min(damin[0]), .ovf(dovf[0]), .unf(dunf[0]), .snap(snap_a), .snap_vld(dvld[0]));

  u_d_counter_param #(.WIDTH(16), .SAT_EN(1), .DECIM(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .clr(clr), .load(load),
    .load_val(load_val), .sticky_clr(sticky_clr), .q(q_b), .at_max(damax[1]),
    .at_min(damin[1]), .ovf(dovf[1]), .unf(dunf[1]), .snap(snap_b), .snap_vld(dvld[1]));

  u_d_counter_param #(.WIDTH(4), .RST_VAL(4'd8), .SAT_EN(0), .DECIM(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .sticky_clr(sticky_clr), .q(q_c), .at_max(damax[2]),
    .at_min(damin[2]), .ovf(dovf[2]), .unf(dunf[2]), .snap(snap_c), .snap_vld(dvld[2]));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [2:0][15:0] q;
    logic [2:0][15:0] snap;
    logic [2:0]       ovf;
    logic [2:0]       unf;
    logic [2:0]       vld;
    logic [2:0]       amax;
    logic [2:0]       amin;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] snap_q0[$], snap_q1[$], snap_q2[$];

  // Reference model state
  longint unsigned mq[3], msnap[3];
  int unsigned     mdc[3];
  bit              movf[3], munf[3];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] @cyc %0d: got %h, expected %h", nm, inst, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = RV[i]; msnap[i] = RV[i]; mdc[i] = 0; movf[i] = 0; munf[i] = 0;
    end
    exp_q.delete(); snap_q0.delete(); snap_q1.delete(); snap_q2.delete();
  endtask

  task automatic check_rst(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_q"}, i, 32'(dq[i]), RV[i]);
      chk({nm, "_snap"}, i, 32'(dsnap[i]), RV[i]);
      chk({nm, "_flags"}, i, {29'd0, dovf[i], dunf[i], dvld[i]}, 32'd0);
    end
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge response.
  task automatic drive(input bit e, input bit ud, input bit c, input bit l,
                       input logic [15:0] lv, input bit sc);
    exp_t r;
    longint unsigned mx;
    bit oe, ue;
    @(posedge clk); #1;
    en = e; u_d = ud; clr = c; load = l; load_val = lv; sticky_clr = sc;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      mx = (64'(1) << WID[i]) - 1;
      oe = 0; ue = 0;
      if (c) begin
        mq[i] = RV[i]; mdc[i] = 0;
      end else if (l) begin
        mq[i] = 64'(lv) & mx;
      end else if (e) begin
        if (ud) begin
          if (mq[i] == mx) begin oe = 1; mq[i] = (SATP[i] != 0) ? mx : 0; end
          else mq[i] = mq[i] + 1;
        end else begin
          if (mq[i] == 0) begin ue = 1; mq[i] = (SATP[i] != 0) ? 0 : mx; end
          else mq[i] = mq[i] - 1;
        end
        mdc[i] = mdc[i] + 1;
        if (mdc[i] == DECP[i]) begin
          mdc[i] = 0; msnap[i] = mq[i]; r.vld[i] = 1'b1;
          case (i)
            0: snap_q0.push_back(16'(mq[i]));
            1: snap_q1.push_back(16'(mq[i]));
            default: snap_q2.push_back(16'(mq[i]));
          endcase
        end
      end
      if (oe) movf[i] = 1; else if (sc) movf[i] = 0;
      if (ue) munf[i] = 1; else if (sc) munf[i] = 0;
      r.q[i] = 16'(mq[i]); r.snap[i] = 16'(msnap[i]);
      r.ovf[i] = movf[i]; r.unf[i] = munf[i];
      r.amax[i] = (mq[i] == mx); r.amin[i] = (mq[i] == 0);
    end
    r.cyc = 32'(cyc + 1);
    exp_q.push_back(r);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    @(posedge clk); @(negedge clk); #1;
    en = 0; u_d = 0; clr = 0; load = 0; sticky_clr = 0; load_val = '0;
    rst = 1; #1;
    model_reset();
    check_rst("rst_async");
    @(posedge clk); #1;
    check_rst("rst_hold");
    @(negedge clk); #1;
    rst = 0;
  endtask

  // Monitor: pop expectations whose edge has occurred and compare.
  exp_t        mr;
  logic [15:0] sv;
  bit          have;
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mr = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("q", i, 32'(dq[i]), 32'(mr.q[i]));
        chk("ovf", i, 32'(dovf[i]), 32'(mr.ovf[i]));
        chk("unf", i, 32'(dunf[i]), 32'(mr.unf[i]));
        chk("at_max", i, 32'(damax[i]), 32'(mr.amax[i]));
        chk("at_min", i, 32'(damin[i]), 32'(mr.amin[i]));
        chk("snap_vld", i, 32'(dvld[i]), 32'(mr.vld[i]));
        chk("snap", i, 32'(dsnap[i]), 32'(mr.snap[i]));
        if (dvld[i]) begin
          have = 0; sv = '0;
          case (i)
            0: if (snap_q0.size() != 0) begin sv = snap_q0.pop_front(); have = 1; end
            1: if (snap_q1.size() != 0) begin sv = snap_q1.pop_front(); have = 1; end
            default: if (snap_q2.size() != 0) begin sv = snap_q2.pop_front(); have = 1; end
          endcase
          chk("snap_strobe_expected", i, 32'(have), 32'd1);
          if (have) chk("snap_strobe_val", i, 32'(dsnap[i]), 32'(sv));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit [8:0]    pat;
    logic [15:0] lv;
    int          sel;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_rst("rst_init");
    @(negedge clk); #1;
    rst = 0;

    // Count up, down, hold
    repeat (10) drive(1, 1, 0, 0, 16'h0, 0);
    repeat (3)  drive(1, 0, 0, 0, 16'h0, 0);
    repeat (5)  drive(0, 1, 0, 0, 16'h0, 0);

    // Wrap/saturate at the top, then at the bottom
    drive(0, 1, 0, 1, 16'hFFFE, 0);
    repeat (3) drive(1, 1, 0, 0, 16'h0, 0);
    drive(0, 0, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 1, 16'h0001, 0);
    repeat (3) drive(1, 0, 0, 0, 16'h0, 0);

    // Clear, then decimation with an enable gap
    drive(1, 1, 1, 0, 16'h0, 1);
    pat = 9'b111111101;
    for (int i = 0; i < 9; i++) drive(pat[i], 1, 0, 0, 16'h0, 0);

    // Priority: clr beats load and step; set beats sticky_clr
    drive(1, 1, 1, 1, 16'h1234, 0);
    drive(0, 1, 0, 1, 16'hFFFF, 1);
    drive(1, 1, 0, 0, 16'h0, 1);
    drive(1, 1, 0, 0, 16'h0, 0);

    // Reset mid-operation, then the 4-bit wrap case
    do_reset();
    repeat (9) drive(1, 1, 0, 0, 16'h0, 0);

    // Randomised traffic with boundary-biased loads and periodic resets
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: lv = 16'hFFFF;
        1: lv = 16'hFFFE;
        2: lv = 16'h0000;
        3: lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
            lv, $urandom_range(0, 7) == 0);
    end

    @(posedge clk); @(negedge clk); #1;
    chk("exp_drain", 0, 32'(exp_q.size()), 32'd0);
    chk("snap_drain", 0, 32'(snap_q0.size()), 32'd0);
    chk("snap_drain", 1, 32'(snap_q1.size()), 32'd0);
    chk("snap_drain", 2, 32'(snap_q2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/u_d_counter_param.md
Name: u_d_counter_param

Overview:
Parametrised successor to the fixed 16-bit up/down feedback counter. It adds generic width, a configurable preset (default midscale), wrap or saturate mode, and synchronous load/clear. It also provides terminal flags, sticky overflow/underflow flags, and a decimated snapshot output with a valid strobe. It sits in the feedback path and is read out by downstream logic at the decimated rate.

Parameters:
WIDTH, 16, counter width in bits (>=2)
RST_VAL, 2**(WIDTH-1), value loaded by rst and clr (midscale)
SAT_EN, 0, 0 = wrap modulo 2**WIDTH; 1 = saturate at 0 / 2**WIDTH-1
DECIM, 8, number of enabled count cycles per snapshot (>=1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  count enable; counting and the decimation counter advance only when en=1
u_d  in  1  direction: 1 = count up, 0 = count down
clr  in  1  synchronous clear to RST_VAL; also clears the decimation counter
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
sticky_clr  in  1  synchronous clear of ovf/unf
q  out  WIDTH  current count
at_max  out  1  combinational, q == 2**WIDTH-1
at_min  out  1  combinational, q == 0
ovf  out  1  sticky overflow flag
unf  out  1  sticky underflow flag
snap  out  WIDTH  count captured at each decimation boundary
snap_vld  out  1  one-cycle pulse when snap updates

Behaviour:
- Reset: rst=1 forces, asynchronously with no clock edge needed:
  - q=RST_VAL, snap=RST_VAL
  - ovf=0, unf=0, snap_vld=0
  - decimation counter dcnt=0
- Per-edge priority for q: clr > load > (en ? step : hold).
- Step, up (u_d=1):
  - q==max, SAT_EN=0: q wraps to 0 and ovf is set.
  - q==max, SAT_EN=1: q holds at max and ovf is set.
- Step, down (u_d=0):
  - q==0, SAT_EN=0: q wraps to max and unf is set.
  - q==0, SAT_EN=1: q holds at 0 and unf is set.
- Otherwise q ±1. Single-cycle step latency: the new q is visible after the edge.
- load or clr suppress that cycle's step, so neither can set ovf/unf.
- Sticky flags:
  - Set in the cycle the boundary event occurs.
  - Cleared by sticky_clr.
  - If set and clear coincide, set wins (flag=1).
  - Flags are not affected by clr or load.
- Decimation, dcnt is $clog2(DECIM) bits (1 bit when DECIM=1):
  - When en=1 and clr=0 and load=0: if dcnt==DECIM-1, then dcnt<=0, snap<=next q (post-step value), snap_vld<=1; else dcnt<=dcnt+1.
  - en=0 holds dcnt.
  - clr zeroes dcnt and produces no snapshot.
  - load holds dcnt.
  - snap_vld=0 in every other cycle.
  - DECIM=1: snapshot on every enabled count.
- snap holds its value between strobes.
- rst mid-operation aborts everything immediately. The first count after rst deasserts occurs on the first enabled edge.
- All arithmetic is unsigned WIDTH-bit. No internal width growth except for boundary detection.

Decomposition:
- Package u_d_counter_pkg: mode constants MODE_WRAP=0, MODE_SAT=1; a function for the midscale default.
- One natural sub-module: u_d_decim_ctrl (dcnt, snapshot strobe, snap register).
- The counter core and flags stay in the top.

Test Plan:
- Reset: pulse rst between edges -> q=0x8000, snap=0x8000, ovf=unf=snap_vld=0 immediately (async).
- Count: en=1, u_d=1 for 10 edges -> q=0x800A; then u_d=0 for 3 edges -> q=0x8007; en=0 for 5 edges -> q stays 0x8007.
- Wrap vs saturate: load 0xFFFE then 3 up-counts.
  - SAT_EN=0 -> 0xFFFF, 0x0000 (ovf=1), 0x0001.
  - SAT_EN=1 -> 0xFFFF, 0xFFFF (ovf=1), 0xFFFF.
  - Mirror from 0x0001 downward -> unf.
- Decimation, DECIM=4: up from 0x8000 with en=1,0,1,1,1,1,1,1,1 -> snap_vld pulses exactly twice, snap=0x8004 then 0x8008; no pulse while en=0.
- Priority: clr=load=en=1 with load_val=0x1234 -> q=0x8000, dcnt=0, no snap_vld. sticky_clr together with an overflow event -> ovf remains 1.
- Width generality: WIDTH=4, RST_VAL=8, DECIM=1, SAT_EN=0 -> 9 up-counts give q=1 with ovf=1, and a snap_vld pulse on every count.
